// File: rtl/ripple_count_sampler.sv
`default_nettype none
// ============================================================================
// Module   : ripple_count_sampler
// Purpose  : Brings an asynchronous, glitch-prone ripple up/down counter value
//            into the clk domain. Each bit is synchronized, the synchronized
//            value must hold steady for STABLE_CYCLES samples before it is
//            accepted, and every accepted change is classified as a step up,
//            a step down (with wrap detection) or an illegal step.
// Options  : SAMPLER_ERR_CNT_EN - when defined, err_cnt counts step_err
//            pulses (saturating at 255); otherwise err_cnt is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module ripple_count_sampler #(
  parameter int WIDTH         = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             dir_in,
  output logic [WIDTH-1:0] cnt_q,
  output logic             dir_q,
  output logic             cnt_vld,
  output logic             wrap_up,
  output logic             wrap_dn,
  output logic             step_err,
  output logic [7:0]       err_cnt
);

  localparam logic [WIDTH-1:0] C_MAX    = '1;
  localparam logic [WIDTH-1:0] C_ONE    = WIDTH'(1);
  localparam logic [4:0]       C_STABLE = 5'(STABLE_CYCLES);

  // Synchronizer chains: index 0 is the metastability-catching flop.
  logic [WIDTH-1:0]       cnt_sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] dir_sync_q;

  // Stability filter state.
  logic [WIDTH-1:0] cand_q;
  logic [3:0]       run_q;
  logic             primed_q;

  // Combinational view of the current edge.
  logic [WIDTH-1:0] samp;
  logic             accept;
  logic [WIDTH-1:0] new_val;
  logic [WIDTH-1:0] delta;
  logic             is_up;
  logic             is_dn;
  logic             wrap_up_d;
  logic             wrap_dn_d;
  logic             step_err_d;

  assign samp  = cnt_sync_q[SYNC_STAGES-1];
  assign dir_q = dir_sync_q[SYNC_STAGES-1];

  // Acceptance rule differs only when a single sample is enough: then the
  // value is taken on the same edge it first appears as a new candidate.
  if (STABLE_CYCLES == 1) begin : g_stable_one
    assign accept  = (samp != cand_q) && (samp != cnt_q);
    assign new_val = samp;
  end else begin : g_stable_multi
    assign accept  = (samp == cand_q) &&
                     (({1'b0, run_q} + 5'd1) == C_STABLE) &&
                     (cand_q != cnt_q);
    assign new_val = cand_q;
  end

  // Step classification is relative to the previously accepted value; the
  // very first acceptance after reset has no meaningful predecessor.
  assign delta      = new_val - cnt_q;
  assign is_up      = (delta == C_ONE);
  assign is_dn      = (delta == C_MAX) && !is_up;
  assign wrap_up_d  = accept && primed_q && is_up && (cnt_q == C_MAX);
  assign wrap_dn_d  = accept && primed_q && is_dn && (cnt_q == '0);
  assign step_err_d = accept && primed_q && !is_up && !is_dn;

  // Shift counter bits and direction through independent synchronizer flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        cnt_sync_q[i] <= '0;
      end
      dir_sync_q <= '0;
    end else begin
      cnt_sync_q[0] <= cnt_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        cnt_sync_q[i] <= cnt_sync_q[i-1];
      end
      dir_sync_q <= {dir_sync_q[SYNC_STAGES-2:0], dir_in};
    end
  end

  // Track how many consecutive edges the synchronized value has been steady.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q <= '0;
      run_q  <= '0;
    end else if (samp != cand_q) begin
      cand_q <= samp;
      run_q  <= 4'd1;
    end else if ({1'b0, run_q} < C_STABLE) begin
      run_q <= run_q + 4'd1;
    end
  end

  // Load accepted value and emit registered single-cycle event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      primed_q <= 1'b0;
      cnt_vld  <= 1'b0;
      wrap_up  <= 1'b0;
      wrap_dn  <= 1'b0;
      step_err <= 1'b0;
    end else begin
      cnt_vld  <= accept;
      wrap_up  <= wrap_up_d;
      wrap_dn  <= wrap_dn_d;
      step_err <= step_err_d;
      if (accept) begin
        cnt_q    <= new_val;
        primed_q <= 1'b1;
      end
    end
  end

`ifdef SAMPLER_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Count illegal steps, updating on the same edge step_err is raised.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (step_err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ripple_count_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ripple_count_sampler
// Purpose  : Directed, self-checking bench for ripple_count_sampler with
//            default parameters. Expected acceptances are queued when the
//            stimulus changes cnt_in and matched against cnt_vld pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ripple_count_sampler;

  localparam int LAT = 4;  // SYNC_STAGES + STABLE_CYCLES at defaults

  logic       clk;
  logic       rst;
  logic [2:0] cnt_in;
  logic       dir_in;
  logic [2:0] cnt_q;
  logic       dir_q;
  logic       cnt_vld;
  logic       wrap_up;
  logic       wrap_dn;
  logic       step_err;
  logic [7:0] err_cnt;

  ripple_count_sampler dut (
    .clk      (clk),
    .rst      (rst),
    .cnt_in   (cnt_in),
    .dir_in   (dir_in),
    .cnt_q    (cnt_q),
    .dir_q    (dir_q),
    .cnt_vld  (cnt_vld),
    .wrap_up  (wrap_up),
    .wrap_dn  (wrap_dn),
    .step_err (step_err),
    .err_cnt  (err_cnt)
  );

  typedef struct {
    int         edge_no;
    logic [2:0] val;
    logic       wu;
    logic       wd;
    logic       se;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   edge_n = 0;
  logic mon_en = 1'b0;

  // Reference of the last accepted value and whether one has been accepted.
  logic [2:0] m_q      = 3'd0;
  logic       m_primed = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a new settled value and queue the acceptance it must produce.
  task automatic drive(input logic [2:0] v, input int hold);
    exp_t       e;
    logic [2:0] d;
    logic       up;
    logic       dn;
    cnt_in = v;
    if (v != m_q) begin
      d         = v - m_q;
      up        = (d == 3'd1);
      dn        = (d == 3'd7);
      e.edge_no = edge_n + LAT;
      e.val     = v;
      e.wu      = m_primed && up && (m_q == 3'd7) && (v == 3'd0);
      e.wd      = m_primed && dn && (m_q == 3'd0) && (v == 3'd7);
      e.se      = m_primed && !up && !dn;
      sb.push_back(e);
      m_q      = v;
      m_primed = 1'b1;
    end
    tick(hold);
  endtask

  // Scoreboard: match every cnt_vld pulse against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (cnt_vld === 1'b1) begin
        chk("vld_expected", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("vld_edge", edge_n, e.edge_no);
          chk("vld_cnt_q", {29'd0, cnt_q}, {29'd0, e.val});
          chk("vld_wrap_up", {31'd0, wrap_up}, {31'd0, e.wu});
          chk("vld_wrap_dn", {31'd0, wrap_dn}, {31'd0, e.wd});
          chk("vld_step_err", {31'd0, step_err}, {31'd0, e.se});
        end
      end else begin
        chk("no_lone_pulse", {29'd0, wrap_up, wrap_dn, step_err}, 32'd0);
      end
      if (sb.size() != 0 && sb[0].edge_no < edge_n) begin
        chk("vld_missing_at_edge", edge_n, sb[0].edge_no);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    rst    = 1'b1;
    cnt_in = 3'd0;
    dir_in = 1'b0;
    tick(3);

    // Reset state.
    chk("rst_cnt_q", {29'd0, cnt_q}, 32'd0);
    chk("rst_dir_q", {31'd0, dir_q}, 32'd0);
    chk("rst_pulses", {28'd0, cnt_vld, wrap_up, wrap_dn, step_err}, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);

    rst    = 1'b0;
    mon_en = 1'b1;

    // Idle at zero: nothing may be accepted or pulsed.
    tick(20);
    chk("idle_cnt_q", {29'd0, cnt_q}, 32'd0);

    // Direction passes through two synchronizer flops.
    dir_in = 1'b1;
    tick(1);
    chk("dir_q_stage1", {31'd0, dir_q}, 32'd0);
    tick(1);
    chk("dir_q_stage2", {31'd0, dir_q}, 32'd1);

    // Count up 1..7 then wrap to 0.
    for (int v = 1; v < 8; v++) drive(3'(v), 6);
    drive(3'd0, 6);
    chk("up_wrap_cnt_q", {29'd0, cnt_q}, 32'd0);

    // Count down with wrap, to 5.
    dir_in = 1'b0;
    drive(3'd7, 6);
    drive(3'd6, 6);
    drive(3'd5, 6);
    chk("down_cnt_q", {29'd0, cnt_q}, 32'd5);

    // Illegal jump 5 -> 2.
    drive(3'd2, 6);
    chk("jump_cnt_q", {29'd0, cnt_q}, 32'd2);
`ifdef SAMPLER_ERR_CNT_EN
    chk("jump_err_cnt", {24'd0, err_cnt}, 32'd1);
`else
    chk("jump_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif

    // Settle at 3, then a one-cycle glitch to 7 must be filtered out.
    drive(3'd3, 6);
    cnt_in = 3'd7;
    tick(1);
    cnt_in = 3'd3;
    tick(8);
    chk("glitch_cnt_q", {29'd0, cnt_q}, 32'd3);

    // Count down 2,1,0,7 (wrap down).
    drive(3'd2, 6);
    drive(3'd1, 6);
    drive(3'd0, 6);
    drive(3'd7, 6);
    chk("wrap_dn_cnt_q", {29'd0, cnt_q}, 32'd7);

    // Reset on the very edge that would accept 4: reset wins.
    cnt_in = 3'd4;
    tick(LAT - 1);
    chk("pre_rst_cnt_q", {29'd0, cnt_q}, 32'd7);
    rst = 1'b1;
    tick(1);
    chk("rst_accept_cnt_q", {29'd0, cnt_q}, 32'd0);
    chk("rst_accept_pulses", {28'd0, cnt_vld, wrap_up, wrap_dn, step_err}, 32'd0);
    chk("rst_accept_dir_q", {31'd0, dir_q}, 32'd0);
    chk("rst_accept_err_cnt", {24'd0, err_cnt}, 32'd0);

    // Restart from zeroed state: 6 is the first acceptance, no step_err.
    rst      = 1'b0;
    m_q      = 3'd0;
    m_primed = 1'b0;
    drive(3'd6, 8);
    chk("post_rst_cnt_q", {29'd0, cnt_q}, 32'd6);
    chk("post_rst_err_cnt", {24'd0, err_cnt}, 32'd0);

    tick(4);
    chk("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ripple_count_sampler.md
RIPPLE_COUNT_SAMPLER -- requirements
Module: ripple_count_sampler

Interface
REQ-001 Parameter WIDTH, default 3: width of the sampled ripple-counter value.
REQ-002 Parameter SYNC_STAGES, default 2, legal range 2..4: flop stages per synchronizer.
REQ-003 Parameter STABLE_CYCLES, default 2, legal range 1..15: consecutive equal synchronized samples required before a value is accepted.
REQ-004 clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 cnt_in  input  WIDTH: asynchronous, glitch-prone output of the upstream ripple up/down counter.
REQ-007 dir_in  input  1: asynchronous up/down control of the upstream counter; 1 = up.
REQ-008 cnt_q  output  WIDTH: last accepted, filtered counter value.
REQ-009 dir_q  output  1: dir_in after SYNC_STAGES synchronizer flops.
REQ-010 cnt_vld  output  1: one-cycle pulse, asserted in the same cycle cnt_q takes a new value.
REQ-011 wrap_up / wrap_dn  output  1 each: one-cycle pulses on an accepted max->0 / 0->max transition.
REQ-012 step_err  output  1: one-cycle pulse on an accepted change whose delta is neither +1 nor -1 modulo 2^WIDTH.
REQ-013 err_cnt  output  8: error count, per REQ-030/REQ-031.

Function
REQ-014 Each bit of cnt_in, and dir_in, SHALL pass through an independent SYNC_STAGES-flop chain; s denotes the synchronized cnt_in.
REQ-015 Filter state SHALL be a candidate register cand (WIDTH) and a run counter run (4 bits).
REQ-016 On each edge:
- if s != cand: cand <= s and run <= 1;
- else if run < STABLE_CYCLES: run <= run+1.
REQ-017 Acceptance SHALL occur on the edge where s == cand, run+1 == STABLE_CYCLES and cand != cnt_q; that edge SHALL load cnt_q <= cand and assert cnt_vld for exactly one cycle.
REQ-018 For STABLE_CYCLES == 1, acceptance SHALL occur on the edge that loads a new cand (s != cand and s != cnt_q).
REQ-019 Latency: with cnt_in settled before edge 1, cnt_q SHALL update on edge SYNC_STAGES+STABLE_CYCLES (4 with default parameters).
REQ-020 A cnt_in glitch shorter than STABLE_CYCLES synchronized cycles SHALL NOT change cnt_q or pulse any output.
REQ-021 Step classification at acceptance, with delta = (cand - cnt_q) mod 2^WIDTH:
- delta == 1: step up;
- delta == 2^WIDTH-1: step down;
- otherwise: step_err.
REQ-022 wrap_up SHALL pulse when an accepted step-up has old cnt_q == 2^WIDTH-1 and new value 0; wrap_dn SHALL pulse on the mirror case (0 -> 2^WIDTH-1).
REQ-023 A primed flag SHALL be cleared by reset and set on the first acceptance; that first acceptance SHALL pulse cnt_vld only, with step_err, wrap_up and wrap_dn suppressed.
REQ-024 wrap_up, wrap_dn and step_err SHALL be mutually exclusive and SHALL assert only together with cnt_vld.
REQ-025 A value matching cnt_q after a glitch (s returns to cnt_q) SHALL NOT produce cnt_vld.
REQ-026 dir_q SHALL be informational only; it SHALL NOT affect classification.

Reset
REQ-027 While rst is high at a rising edge, the following SHALL load 0:
- all synchronizer flops, cand, run and primed;
- cnt_q, dir_q, cnt_vld, wrap_up, wrap_dn, step_err and err_cnt.
REQ-028 rst SHALL take priority over every simultaneous event, including an acceptance on the same edge.
REQ-029 After rst deasserts, filtering SHALL restart from the zeroed state; a nonzero settled cnt_in SHALL be accepted after SYNC_STAGES+STABLE_CYCLES edges without flagging step_err.

Configuration
REQ-030 With SAMPLER_ERR_CNT_EN defined, err_cnt SHALL increment by 1 on each step_err pulse and saturate at 255; only rst clears it.
REQ-031 Without SAMPLER_ERR_CNT_EN, err_cnt SHALL be tied to 0, no counter logic SHALL be present, and all other behaviour SHALL be unchanged.

Verification
REQ-032 Defaults; reset, then hold cnt_in=0 -> cnt_q=0; no cnt_vld or any other pulse for 20 cycles.
REQ-033 cnt_in steps 0,1,...,7,0 with each value held 6 cycles -> 8 cnt_vld pulses; each update lands 4 edges after its change; a single wrap_up pulse on 7->0; step_err never asserts.
REQ-034 cnt_q=3 settled; a 1-cycle glitch to 7 on cnt_in -> cnt_q stays 3; no pulses.
REQ-035 cnt_q=5; cnt_in jumps to 2 and holds -> cnt_vld and step_err pulse together, cnt_q=2; err_cnt=1 with the macro defined, 0 without.
REQ-036 Counting down 1,0,7 -> wrap_dn pulses on 0->7; rst asserted on the same edge as an acceptance -> all outputs 0 on the next cycle; after release, cnt_in held at 6 -> cnt_q=6 and cnt_vld pulses with no step_err.
